// File: rtl/raster_tile_scheduler.sv
// Raster tile scheduler: clips a triangle's bounding box to the screen and
// walks it row-major, emitting one pixel record per cycle on a valid/ready
// stream.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   tri_in/valid/ready  triangle handoff from setup
//   pix_out/valid/ready pixel stream to the barycentric/shading pipeline
//   pix_last            current pixel is the last of its triangle
//   tri_done            one-cycle pulse when a triangle completes (also empty)
//   flush               synchronous abort of the current triangle
//   busy                scheduler is not idle
//   pix_count           free-running count of transferred pixels (mod 2^32)

package raster_tile_scheduler_pkg;
  localparam int unsigned COORD_W = 16;
  localparam int unsigned ID_W    = 16;
  localparam int unsigned ATTR_W  = 32;

  typedef struct packed {
    logic [ID_W-1:0]    tri_id;
    logic [ATTR_W-1:0]  attr;
    logic [COORD_W-1:0] bbox_min_x;
    logic [COORD_W-1:0] bbox_max_x;
    logic [COORD_W-1:0] bbox_min_y;
    logic [COORD_W-1:0] bbox_max_y;
  } triangle_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    triangle_state_t    tri_state;
  } pixel_state_t;
endpackage

module raster_tile_scheduler
  import raster_tile_scheduler_pkg::*;
#(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic            clk,
  input  logic            rstn,
  input  triangle_state_t tri_in,
  input  logic            tri_valid,
  output logic            tri_ready,
  output pixel_state_t    pix_out,
  output logic            pix_valid,
  input  logic            pix_ready,
  output logic            pix_last,
  output logic            tri_done,
  input  logic            flush,
  output logic            busy,
  output logic [31:0]     pix_count
);

  localparam int unsigned CNT_W = 32;
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRAVERSE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  triangle_state_t    tri_q, tri_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  logic [COORD_W-1:0] xe_c, ye_c;
  logic               fire_c;

  pixel_state_t       pix_out_d;
  logic               pix_valid_d, pix_last_d, tri_done_d, tri_ready_d, busy_d;
  logic [CNT_W-1:0]   pix_count_d;

  // Clipped far corner of the latched box; the near corner needs no clip
  // because an off-screen near corner simply makes the box empty.
  assign xe_c   = (tri_q.bbox_max_x > X_LIM) ? X_LIM : tri_q.bbox_max_x;
  assign ye_c   = (tri_q.bbox_max_y > Y_LIM) ? Y_LIM : tri_q.bbox_max_y;
  assign fire_c = pix_valid & pix_ready;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      tri_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      tri_done  <= 1'b0;
      tri_ready <= 1'b1;
      busy      <= 1'b0;
      pix_count <= '0;
    end else begin
      state_q   <= state_d;
      tri_q     <= tri_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pix_out   <= pix_out_d;
      pix_valid <= pix_valid_d;
      pix_last  <= pix_last_d;
      tri_done  <= tri_done_d;
      tri_ready <= tri_ready_d;
      busy      <= busy_d;
      pix_count <= pix_count_d;
    end
  end

  // Next-state, traversal counters and next output values
  always_comb begin
    state_d     = state_q;
    tri_d       = tri_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_count_d = fire_c ? (pix_count + CNT_W'(1)) : pix_count;

    case (state_q)
      IDLE: begin
        if (tri_valid && tri_ready) begin
          tri_d   = tri_in;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if ((tri_q.bbox_min_x > xe_c) || (tri_q.bbox_min_y > ye_c)) begin
          state_d = DONE;
        end else begin
          x_d     = tri_q.bbox_min_x;
          y_d     = tri_q.bbox_min_y;
          state_d = TRAVERSE;
        end
      end
      TRAVERSE: begin
        if (fire_c) begin
          if (pix_last) begin
            state_d = DONE;
          end else if (x_q == xe_c) begin
            x_d = tri_q.bbox_min_x;
            y_d = y_q + COORD_W'(1);
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything; an IDLE handshake in the same cycle is dropped
    if (flush) begin
      state_d = IDLE;
      tri_d   = tri_q;
    end

    pix_valid_d         = (state_d == TRAVERSE);
    pix_last_d          = (state_d == TRAVERSE) && (x_d == xe_c) && (y_d == ye_c);
    tri_done_d          = (state_d == DONE);
    tri_ready_d         = (state_d == IDLE);
    busy_d              = (state_d != IDLE);
    pix_out_d.x         = x_d;
    pix_out_d.y         = y_d;
    pix_out_d.tri_state = tri_d;
  end

endmodule

// File: tb/tb_raster_tile_scheduler.sv
// Self-checking bench for raster_tile_scheduler: table of bounding boxes with
// expected pixel counts and last pixels, a reference model feeding a
// scoreboard queue, and hand sequences for backpressure, flush and reset.
module tb_raster_tile_scheduler;
  import raster_tile_scheduler_pkg::*;

  localparam int unsigned SW = 160;
  localparam int unsigned SH = 120;
  localparam int MAX_WAIT = 400;
  localparam int NVEC = 8;

  typedef struct {
    string       name;
    logic [15:0] min_x;
    logic [15:0] max_x;
    logic [15:0] min_y;
    logic [15:0] max_y;
    int          npix;
    logic [15:0] last_x;
    logic [15:0] last_y;
  } vec_t;

  typedef struct {
    pixel_state_t pix;
    logic         last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn;
  triangle_state_t tri_in;
  logic            tri_valid;
  logic            tri_ready;
  pixel_state_t    pix_out;
  logic            pix_valid;
  logic            pix_ready;
  logic            pix_last;
  logic            tri_done;
  logic            flush;
  logic            busy;
  logic [31:0]     pix_count;

  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [31:0] exp_count = '0;
  logic [15:0] seen_last_x = '0;
  logic [15:0] seen_last_y = '0;
  int          seen_last_n = 0;
  logic [15:0] next_id = 16'd1;
  vec_t        vecs[NVEC];

  raster_tile_scheduler #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .tri_in   (tri_in),
    .tri_valid(tri_valid),
    .tri_ready(tri_ready),
    .pix_out  (pix_out),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_last (pix_last),
    .tri_done (tri_done),
    .flush    (flush),
    .busy     (busy),
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: every handshaken pixel is matched against the model queue
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        check("pix_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("pix_x", 64'(pix_out.x), 64'(e.pix.x));
        check("pix_y", 64'(pix_out.y), 64'(e.pix.y));
        check("pix_id", 64'(pix_out.tri_state.tri_id), 64'(e.pix.tri_state.tri_id));
        check("pix_attr", 64'(pix_out.tri_state.attr), 64'(e.pix.tri_state.attr));
        check("pix_last", 64'(pix_last), 64'(e.last));
      end
      if (pix_last) begin
        seen_last_x = pix_out.x;
        seen_last_y = pix_out.y;
        seen_last_n++;
      end
    end
  end

  function automatic triangle_state_t mk_tri(input vec_t v);
    triangle_state_t t;
    t.tri_id     = next_id;
    t.attr       = $urandom;
    t.bbox_min_x = v.min_x;
    t.bbox_max_x = v.max_x;
    t.bbox_min_y = v.min_y;
    t.bbox_max_y = v.max_y;
    next_id      = next_id + 16'd1;
    return t;
  endfunction

  // Reference model: expected pixel sequence of a clipped row-major walk
  task automatic push_model(input triangle_state_t t, output int n);
    int   xe;
    int   ye;
    exp_t e;
    xe = int'(t.bbox_max_x);
    ye = int'(t.bbox_max_y);
    if (xe > int'(SW) - 1) xe = int'(SW) - 1;
    if (ye > int'(SH) - 1) ye = int'(SH) - 1;
    n = 0;
    for (int y = int'(t.bbox_min_y); y <= ye; y++) begin
      for (int x = int'(t.bbox_min_x); x <= xe; x++) begin
        e.pix.x         = 16'(x);
        e.pix.y         = 16'(y);
        e.pix.tri_state = t;
        e.last          = (x == xe) && (y == ye);
        exp_q.push_back(e);
        n++;
      end
    end
  endtask

  // Handshake one triangle, then check the SETUP cycle
  task automatic send_tri(input triangle_state_t t);
    @(posedge clk);
    #1;
    check("send_ready", 64'(tri_ready), 64'(1));
    tri_in    = t;
    tri_valid = 1'b1;
    @(posedge clk);
    #1;
    tri_valid = 1'b0;
    @(negedge clk);
    check("setup_ready", 64'(tri_ready), 64'(0));
    check("setup_busy", 64'(busy), 64'(1));
    check("setup_valid", 64'(pix_valid), 64'(0));
  endtask

  task automatic wait_done(input string name, input int npix,
                           input logic [15:0] lx, input logic [15:0] ly);
    bit done;
    int first;
    int last0;
    done  = 1'b0;
    first = -1;
    last0 = seen_last_n;
    for (int n = 0; n < MAX_WAIT && !done; n++) begin
      @(negedge clk);
      if (pix_valid && first < 0) first = n;
      if (tri_done) begin
        done = 1'b1;
        check({name, "_done_valid"}, 64'(pix_valid), 64'(0));
      end
    end
    check({name, "_done_seen"}, 64'(done), 64'(1));
    exp_count = exp_count + 32'(npix);
    check({name, "_pix_count"}, 64'(pix_count), 64'(exp_count));
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    if (npix > 0) begin
      check({name, "_first_lat"}, 64'(first), 64'(0));
      check({name, "_last_n"}, 64'(seen_last_n - last0), 64'(1));
      check({name, "_last_x"}, 64'(seen_last_x), 64'(lx));
      check({name, "_last_y"}, 64'(seen_last_y), 64'(ly));
    end else begin
      check({name, "_no_pix"}, 64'(first), 64'(-1));
    end
    exp_q.delete();
    @(negedge clk);
    check({name, "_pulse_1cyc"}, 64'(tri_done), 64'(0));
    check({name, "_idle_ready"}, 64'(tri_ready), 64'(1));
    check({name, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic run_vec(input vec_t v);
    triangle_state_t t;
    int n;
    t = mk_tri(v);
    push_model(t, n);
    check({v.name, "_model_n"}, 64'(n), 64'(v.npix));
    send_tri(t);
    wait_done(v.name, v.npix, v.last_x, v.last_y);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!pix_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, 64'(pix_valid), 64'(1));
  endtask

  initial begin
    triangle_state_t t;
    vec_t            v;
    pixel_state_t    hold;
    int              n;
    bit              pulsed;

    vecs[0] = '{"basic",   16'd2,   16'd4,   16'd1,   16'd2,   6,  16'd4,   16'd2};
    vecs[1] = '{"clip",    16'd150, 16'd200, 16'd115, 16'd130, 50, 16'd159, 16'd119};
    vecs[2] = '{"inv_x",   16'd10,  16'd5,   16'd0,   16'd3,   0,  16'd0,   16'd0};
    vecs[3] = '{"off_x",   16'd170, 16'd180, 16'd0,   16'd3,   0,  16'd0,   16'd0};
    vecs[4] = '{"single",  16'd7,   16'd7,   16'd9,   16'd9,   1,  16'd7,   16'd9};
    vecs[5] = '{"edge",    16'd158, 16'd170, 16'd119, 16'd119, 2,  16'd159, 16'd119};
    vecs[6] = '{"off_y",   16'd0,   16'd1,   16'd120, 16'd125, 0,  16'd0,   16'd0};
    vecs[7] = '{"inv_y",   16'd0,   16'd0,   16'd5,   16'd4,   0,  16'd0,   16'd0};

    rstn      = 1'b0;
    tri_valid = 1'b0;
    tri_in    = '0;
    pix_ready = 1'b1;
    flush     = 1'b0;

    #12;
    check("rst_ready", 64'(tri_ready), 64'(1));
    check("rst_valid", 64'(pix_valid), 64'(0));
    check("rst_last", 64'(pix_last), 64'(0));
    check("rst_done", 64'(tri_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_count", 64'(pix_count), 64'(0));
    check("rst_pix_out", 64'(pix_out != '0), 64'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Backpressure on a 2x1 box: ready 1,0,0,1 starting with the first valid cycle
    v = '{"bp", 16'd20, 16'd21, 16'd5, 16'd5, 2, 16'd21, 16'd5};
    t = mk_tri(v);
    push_model(t, n);
    hold.x         = 16'd21;
    hold.y         = 16'd5;
    hold.tri_state = t;
    send_tri(t);
    fork
      begin
        @(negedge clk);
        check("bp_first_valid", 64'(pix_valid), 64'(1));
        @(posedge clk);
        #1;
        pix_ready = 1'b0;
        @(negedge clk);
        check("bp_stall1_out", 64'(pix_out != hold), 64'(0));
        check("bp_stall1_last", 64'(pix_last), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_stall2_out", 64'(pix_out != hold), 64'(0));
        check("bp_stall2_valid", 64'(pix_valid), 64'(1));
        @(posedge clk);
        #1;
        pix_ready = 1'b1;
      end
      wait_done(v.name, v.npix, v.last_x, v.last_y);
    join

    // Flush mid-triangle: third transfer coincides with flush
    t = mk_tri(vecs[0]);
    push_model(t, n);
    send_tri(t);
    @(negedge clk);
    wait_valid("flush");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(pix_valid), 64'(0));
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_ready", 64'(tri_ready), 64'(1));
    check("flush_left", 64'(exp_q.size()), 64'(3));
    exp_q.delete();
    exp_count = exp_count + 32'd3;
    check("flush_count", 64'(pix_count), 64'(exp_count));
    pulsed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (tri_done) pulsed = 1'b1;
      @(negedge clk);
    end
    check("flush_no_done", 64'(pulsed), 64'(0));
    run_vec(vecs[0]);

    // Handshake coinciding with flush in IDLE is discarded
    @(posedge clk);
    #1;
    tri_in    = mk_tri(vecs[4]);
    tri_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    tri_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", 64'(busy), 64'(0));
    check("idle_flush_ready", 64'(tri_ready), 64'(1));
    @(negedge clk);
    @(negedge clk);
    check("idle_flush_novalid", 64'(pix_valid), 64'(0));
    check("idle_flush_count", 64'(pix_count), 64'(exp_count));

    // Asynchronous reset between clock edges during traversal
    t = mk_tri(vecs[1]);
    push_model(t, n);
    send_tri(t);
    @(negedge clk);
    wait_valid("areset");
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("areset_valid", 64'(pix_valid), 64'(0));
    check("areset_ready", 64'(tri_ready), 64'(1));
    check("areset_busy", 64'(busy), 64'(0));
    check("areset_count", 64'(pix_count), 64'(0));
    exp_q.delete();
    exp_count = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
